// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state
// encoding and the bit-counter width helper.
package pattern_tx_pkg;

    // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_RPT_W = 4;

    // Bits needed to count down from width-1 to 0 (at least one bit).
    function automatic int bit_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEF_CNT_W = bit_cnt_w(DEF_WIDTH);

endpackage

// File: rtl/pattern_tx_if.sv
// Handshake and data bundle between a requester and pattern_tx.
interface pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [RPT_W-1:0] repeat_cnt;
    logic             abort;
    logic             s;
    logic             valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    // Requester side: issues commands, observes the serial stream.
    modport master (
        output start, pattern, repeat_cnt, abort,
        input  s, valid, frame_start, busy, done
    );

    // Transmitter side.
    modport slave (
        input  start, pattern, repeat_cnt, abort,
        output s, valid, frame_start, busy, done
    );
endinterface

// File: rtl/pattern_shift_reg.sv
// WIDTH-bit left-shifting register with a shadow copy of the last loaded
// pattern so repeated frames can be reloaded without the source input.
module pattern_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb_d
);
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;

    // Next-value selection: fresh load beats reload beats shift beats hold.
    always_comb begin
        shreg_d  = shreg_q;
        shadow_d = shadow_q;
        if (load) begin
            shreg_d  = din;
            shadow_d = din;
        end else if (reload) begin
            shreg_d = shadow_q;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Data-only storage; the controller never relies on its reset value.
    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
        shadow_q <= shadow_d;
    end

    // Exposed so the owner can register the serial bit in the same edge.
    assign msb_d = shreg_d[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Moore serial pattern transmitter: sends a latched WIDTH-bit pattern MSB
// first, repeated back-to-back for max(repeat_cnt,1) frames, followed by a
// one-cycle done pulse. All outputs come straight from flops.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RPT_W = DEF_RPT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    pattern_tx_if.slave  bus
);
    localparam int               CNT_W    = bit_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [RPT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic s_q, s_d;
    logic valid_q, valid_d;
    logic frame_start_q, frame_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic load, reload, shift;
    logic msb_d;

    pattern_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk    (clk),
        .load   (load),
        .reload (reload),
        .shift  (shift),
        .din    (bus.pattern),
        .msb_d  (msb_d)
    );

    // Next-state, counter updates and shift-register control.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
        reload      = 1'b0;
        shift       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here
                if (bus.start) begin
                    state_d     = ST_SHIFT;
                    load        = 1'b1;
                    bit_cnt_d   = BIT_LAST;
                    frame_cnt_d = (bus.repeat_cnt == '0) ? RPT_ONE : bus.repeat_cnt;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == '0) begin
                    if (frame_cnt_q > RPT_ONE) begin
                        reload      = 1'b1;
                        frame_cnt_d = frame_cnt_q - RPT_ONE;
                        bit_cnt_d   = BIT_LAST;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they land in flops.
    always_comb begin
        s_d           = 1'b0;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        if (state_d == ST_SHIFT) begin
            s_d           = msb_d;
            valid_d       = 1'b1;
            busy_d        = 1'b1;
            frame_start_d = (bit_cnt_d == BIT_LAST);
        end else if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    // Control and output registers; reset overrides start and abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            s_q           <= 1'b0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            s_q           <= s_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.s           = s_q;
    assign bus.valid       = valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed and randomized transmissions compared
// cycle by cycle against a frame-level reference model.
module tb_pattern_tx;
    localparam int W = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pattern_tx_if #(.WIDTH(W), .RPT_W(R)) bus ();

    pattern_tx #(.WIDTH(W), .RPT_W(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observed outputs packed as {s, valid, frame_start, busy, done}.
    logic [4:0] obs;
    assign obs = {bus.s, bus.valid, bus.frame_start, bus.busy, bus.done};

    // Reference: expected outputs k cycles after the accepting edge's cycle.
    // The stream is the pattern repeated n times, then one done cycle, then idle.
    function automatic logic [4:0] model(input logic [W-1:0] p, input int r, input int k);
        int n;
        int tot;
        int b;
        n   = (r == 0) ? 1 : r;
        tot = n * W;
        if (k < tot) begin
            b = k % W;
            return {p[W-1-b], 1'b1, (b == 0), 1'b1, 1'b0};
        end else if (k == tot) begin
            return 5'b00001;
        end
        return 5'b00000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.pattern    = 4'b1111;
        bus.repeat_cnt = 4'd3;
        step();
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 5'b00000);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL after_reset: got %b expected %b", obs, 5'b00000);
        end
    endtask

    // One full transmission; pattern/repeat inputs are scrambled while busy.
    task automatic test_frames(input logic [W-1:0] p, input int r, input string tag);
        int n;
        int tot;
        logic [4:0] exp;
        n   = (r == 0) ? 1 : r;
        tot = n * W;
        bus.pattern    = p;
        bus.repeat_cnt = R'(r);
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k <= tot + 1; k++) begin
            exp = model(p, r, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, k + 1, obs, exp);
            end
            bus.pattern    = W'($urandom);
            bus.repeat_cnt = R'($urandom);
            if (k < tot + 1) step();
        end
    endtask

    task automatic test_start_while_busy();
        logic [4:0] exp;
        bus.pattern    = 4'b1100;
        bus.repeat_cnt = 4'd1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            exp = model(4'b1100, 1, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL start_busy cycle %0d: got %b expected %b", k + 1, obs, exp);
            end
            // k==1: restart mid-frame with a new pattern; k==4: start during DONE
            bus.start = (k == 1) || (k == 4);
            if (k == 1) bus.pattern = 4'b0011;
            if (k < 6) step();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_abort();
        logic [4:0] exp;
        bus.pattern    = 4'b1111;
        bus.repeat_cnt = 4'd2;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            exp = model(4'b1111, 2, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", k + 1, obs, exp);
            end
            if (k == 2) bus.abort = 1'b1;
            step();
        end
        bus.abort = 1'b0;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL abort_idle: got %b expected %b", obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL abort_no_done: got %b expected %b", obs, 5'b00000);
        end
        test_frames(W'($urandom), int'($urandom_range(1, 3)), "after_abort");
    endtask

    task automatic test_reset_midframe();
        logic [4:0] exp;
        bus.pattern    = 4'b1010;
        bus.repeat_cnt = 4'd1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            exp = model(4'b1010, 1, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_mid_pre cycle %0d: got %b expected %b", k + 1, obs, exp);
            end
            if (k == 1) rst_n = 1'b0;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL rst_mid_zero %0d: got %b expected %b", k, obs, 5'b00000);
            end
            if (k == 1) rst_n = 1'b1;
            if (k < 2) step();
        end
        test_frames(W'($urandom), int'($urandom_range(0, 3)), "after_rst");
    endtask

    task automatic test_random();
        int gap;
        for (int t = 0; t < 8; t++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.abort = 1'($urandom);
                step();
                checks++;
                if (obs !== 5'b00000) begin
                    errors++;
                    $display("FAIL random_gap %0d: got %b expected %b", t, obs, 5'b00000);
                end
            end
            bus.abort = 1'b0;
            test_frames(W'($urandom), int'($urandom_range(0, 5)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        test_reset();
        test_frames(4'b1011, 1, "single");
        test_frames(4'b0110, 3, "repeat3");
        test_frames(4'b1001, 0, "zero_rpt");
        test_start_while_busy();
        test_abort();
        test_reset_midframe();
        test_random();
        test_frames(W'($urandom), 15, "max_rpt");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
